mult_arbiter: RTL and testbench

Shares the single `multiply` instance between up to NREQ requesters, e.g. gencon digit-entry (operand × 10) and gencon result-multiply. The arbiter grants one requester at a time in round-robin order and drives the multiplier's start/INn1/INn2. It captures `out` on `finish` and returns the product to the granted requester with a one-cycle done pulse. It sits between the controller(s) and the multiply unit; the multiplier's own ports are unchanged.

---
 rtl/mult_arb_pkg.sv | 25 ++
 rtl/rr_picker.sv | 35 +++
 rtl/mult_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mult_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the multiplier arbiter and its round-robin picker.
// The optional WAIT-state timeout is enabled with MULT_ARB_TIMEOUT_EN.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int MULT_ARB_W       = 16;
    localparam int MULT_ARB_NREQ    = 2;
    localparam int MULT_ARB_TIMEOUT = 64;

    // Counter must be able to hold the value TIMEOUT itself.
    function automatic int arb_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    function automatic int arb_idx_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Kept generic so other shared units can reuse it.
module rr_picker
    import mult_arb_pkg::*;
#(
    parameter int NREQ = MULT_ARB_NREQ,
    parameter int IW   = arb_idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_oh,
    output logic [IW-1:0]   gnt_idx,
    output logic            any
);

    logic [IW-1:0] idx_s;
    logic          hit_s;

    // Scan upward from ptr; the first hit wins and masks the rest.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s          = IW'((int'(ptr) + k) % NREQ);
            hit_s          = req[idx_s] & ~any;
            gnt_oh[idx_s]  = gnt_oh[idx_s] | hit_s;
            gnt_idx        = hit_s ? idx_s : gnt_idx;
            any            = any | hit_s;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiply unit between NREQ requesters.
// Define MULT_ARB_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT cycles (err pulses with done).
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ    = MULT_ARB_NREQ,
    parameter int W       = MULT_ARB_W,
    parameter int TIMEOUT = MULT_ARB_TIMEOUT
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [W-1:0]      result,
    output logic              err,
    output logic              busy,
    output logic              mult_start,
    output logic [W-1:0]      mult_in1,
    output logic [W-1:0]      mult_in2,
    input  logic [W-1:0]      mult_out,
    input  logic              mult_finish
);

    localparam int IW = arb_idx_width(NREQ);

    if (NREQ < 2 || NREQ > 8 || W < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("mult_arbiter: unsupported parameter combination");
    end

    arb_state_t      state_q,  state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   gidx_q,   gidx_d;
    logic [NREQ-1:0] gnt_q,    gnt_d;
    logic [NREQ-1:0] done_q,   done_d;
    logic [W-1:0]    result_q, result_d;
    logic            busy_q,   busy_d;
    logic            start_q,  start_d;
    logic [W-1:0]    in1_q,    in1_d;
    logic [W-1:0]    in2_q,    in2_d;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CNT_W = arb_cnt_width(TIMEOUT);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    logic [W-1:0]    a_arr_s [NREQ];
    logic [W-1:0]    b_arr_s [NREQ];
    logic [NREQ-1:0] pick_oh_s;
    logic [IW-1:0]   pick_idx_s;
    logic            pick_any_s;

    for (genvar i = 0; i < NREQ; i++) begin : g_split
        assign a_arr_s[i] = op_a[i*W +: W];
        assign b_arr_s[i] = op_b[i*W +: W];
    end

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req     (req),
        .ptr     (rr_ptr_q),
        .gnt_oh  (pick_oh_s),
        .gnt_idx (pick_idx_s),
        .any     (pick_any_s)
    );

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        result_d = result_q;
        start_d  = 1'b0;
        in1_d    = in1_q;
        in2_d    = in2_q;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    state_d = ISSUE;
                    gidx_d  = pick_idx_s;
                    gnt_d   = pick_oh_s;
                    start_d = 1'b1;
                    in1_d   = a_arr_s[pick_idx_s];
                    in2_d   = b_arr_s[pick_idx_s];
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (mult_finish) begin
                    state_d  = RESP;
                    result_d = mult_out;
                    done_d   = gnt_q;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
                    state_d  = RESP;
                    result_d = '0;
                    done_d   = gnt_q;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                else begin
                    state_d = WAIT;
                end
`endif
            end
            RESP: begin
                state_d  = IDLE;
                gnt_d    = '0;
                rr_ptr_d = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any in-flight operation without a done.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            in1_q    <= '0;
            in2_q    <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign result     = result_q;
    assign busy       = busy_q;
    assign mult_start = start_q;
    assign mult_in1   = in1_q;
    assign mult_in2   = in2_q;
`ifdef MULT_ARB_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a fixed-latency multiplier model.
// Build with MULT_ARB_TIMEOUT_EN to exercise the WAIT timeout path.
module tb_mult_arbiter;

    localparam int NREQ    = 2;
    localparam int W       = 16;
    localparam int TIMEOUT = 8;

    logic              clk;
    logic              nRST;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] op_a;
    logic [NREQ*W-1:0] op_b;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [W-1:0]      result;
    logic              err;
    logic              busy;
    logic              mult_start;
    logic [W-1:0]      mult_in1;
    logic [W-1:0]      mult_in2;
    logic [W-1:0]      mult_out;
    logic              mult_finish;

    logic              mdl_fin;
    logic              tb_fin;
    logic [W-1:0]      mdl_p;
    int                mdl_cnt;
    bit                mdl_en;

    int total;
    int bad;

    typedef struct {
        logic [1:0]  req;
        logic [15:0] a0;
        logic [15:0] b0;
        logic [15:0] a1;
        logic [15:0] b1;
        logic [1:0]  exp_done;
        logic [15:0] exp_res;
    } vec_t;

    vec_t vecs [12];
    vec_t hv;

    mult_arbiter #(
        .NREQ    (NREQ),
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .nRST        (nRST),
        .req         (req),
        .op_a        (op_a),
        .op_b        (op_b),
        .gnt         (gnt),
        .done        (done),
        .result      (result),
        .err         (err),
        .busy        (busy),
        .mult_start  (mult_start),
        .mult_in1    (mult_in1),
        .mult_in2    (mult_in2),
        .mult_out    (mult_out),
        .mult_finish (mult_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mult_finish = mdl_fin | tb_fin;

    // Multiplier model: finish pulses 5 cycles after a sampled start.
    always @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            mdl_cnt  <= 0;
            mdl_fin  <= 1'b0;
            mdl_p    <= '0;
            mult_out <= '0;
        end else begin
            mdl_fin <= 1'b0;
            if (mult_start && mdl_en) begin
                mdl_cnt <= 5;
                mdl_p   <= 16'(mult_in1 * mult_in2);
            end else if (mdl_cnt == 1) begin
                mdl_cnt  <= 0;
                mdl_fin  <= 1'b1;
                mult_out <= mdl_p;
            end else if (mdl_cnt > 1) begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_start(output bit got);
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (mult_start) got = 1'b1;
        end
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (done != 2'b00) got = 1'b1;
        end
    endtask

    // One operation: apply, watch start/operands, then check the done cycle.
    task automatic run_op(input vec_t v, input string tag);
        int          starts;
        logic [15:0] s1;
        logic [15:0] s2;
        bit          got;
        req    = v.req;
        op_a   = {v.a1, v.a0};
        op_b   = {v.b1, v.b0};
        starts = 0;
        s1     = '0;
        s2     = '0;
        got    = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (mult_start) begin
                starts++;
                s1   = mult_in1;
                s2   = mult_in2;
                op_a = 32'hDEAD_BEEF;
                op_b = 32'h0BAD_F00D;
            end
            if (done != 2'b00) got = 1'b1;
        end
        chk($sformatf("%s done", tag),   32'(done),   32'(v.exp_done));
        chk($sformatf("%s result", tag), 32'(result), 32'(v.exp_res));
        chk($sformatf("%s gnt", tag),    32'(gnt),    32'(v.exp_done));
        chk($sformatf("%s err", tag),    32'(err),    32'd0);
        chk($sformatf("%s busy", tag),   32'(busy),   32'd1);
        chk($sformatf("%s starts", tag), 32'(starts), 32'd1);
        chk($sformatf("%s in1", tag),    32'(s1),     32'(v.exp_done[1] ? v.a1 : v.a0));
        chk($sformatf("%s in2", tag),    32'(s2),     32'(v.exp_done[1] ? v.b1 : v.b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int n;
        int seen;

        vecs[0]  = '{2'b01, 16'h007B, 16'h000A, 16'h0000, 16'h0000, 2'b01, 16'h04CE};
        vecs[1]  = '{2'b10, 16'h0000, 16'h0000, 16'h0002, 16'h0003, 2'b10, 16'h0006};
        vecs[2]  = '{2'b11, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 2'b01, 16'h000C};
        vecs[3]  = '{2'b10, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 2'b10, 16'h001E};
        vecs[4]  = '{2'b11, 16'h0101, 16'h0002, 16'h0011, 16'h0003, 2'b01, 16'h0202};
        vecs[5]  = '{2'b11, 16'h0101, 16'h0002, 16'h0011, 16'h0003, 2'b10, 16'h0033};
        vecs[6]  = '{2'b11, 16'h0101, 16'h0002, 16'h0011, 16'h0003, 2'b01, 16'h0202};
        vecs[7]  = '{2'b11, 16'h0101, 16'h0002, 16'h0011, 16'h0003, 2'b10, 16'h0033};
        vecs[8]  = '{2'b11, 16'h0101, 16'h0002, 16'h0011, 16'h0003, 2'b01, 16'h0202};
        vecs[9]  = '{2'b11, 16'h0101, 16'h0002, 16'h0011, 16'h0003, 2'b10, 16'h0033};
        vecs[10] = '{2'b01, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 2'b01, 16'h0001};
        vecs[11] = '{2'b01, 16'h8000, 16'h0002, 16'h0000, 16'h0000, 2'b01, 16'h0000};

        total  = 0;
        bad    = 0;
        nRST   = 1'b0;
        req    = '0;
        op_a   = '0;
        op_b   = '0;
        tb_fin = 1'b0;
        mdl_en = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst gnt",    32'(gnt),        32'd0);
        chk("rst done",   32'(done),       32'd0);
        chk("rst result", 32'(result),     32'd0);
        chk("rst err",    32'(err),        32'd0);
        chk("rst busy",   32'(busy),       32'd0);
        chk("rst start",  32'(mult_start), 32'd0);
        chk("rst in1",    32'(mult_in1),   32'd0);
        chk("rst in2",    32'(mult_in2),   32'd0);
        nRST = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Spurious finish while idle.
        req = '0;
        @(negedge clk);
        tb_fin = 1'b1;
        @(negedge clk);
        tb_fin = 1'b0;
        chk("idle_fin busy", 32'(busy), 32'd0);
        chk("idle_fin done", 32'(done), 32'd0);
        @(negedge clk);
        chk("idle_fin done2", 32'(done), 32'd0);

        // Spurious finish during ISSUE, real finish later.
        req  = 2'b01;
        op_a = {16'h0000, 16'h0007};
        op_b = {16'h0000, 16'h0006};
        wait_start(got);
        chk("issue_fin start seen", 32'(got), 32'd1);
        tb_fin = 1'b1;
        @(negedge clk);
        tb_fin = 1'b0;
        chk("issue_fin done", 32'(done), 32'd0);
        chk("issue_fin busy", 32'(busy), 32'd1);
        chk("issue_fin gnt",  32'(gnt),  32'd1);
        wait_done(got);
        chk("issue_fin real done", 32'(done),   32'd1);
        chk("issue_fin result",    32'(result), 32'h2A);
        req = '0;

        // Reset during WAIT, then check the pointer restarted at 0.
        @(negedge clk);
        req  = 2'b01;
        op_a = {16'h0000, 16'h1111};
        op_b = {16'h0000, 16'h0002};
        wait_start(got);
        chk("rst_mid start seen", 32'(got), 32'd1);
        repeat (2) @(negedge clk);
        nRST = 1'b0;
        #1;
        chk("rst_mid gnt",    32'(gnt),        32'd0);
        chk("rst_mid busy",   32'(busy),       32'd0);
        chk("rst_mid done",   32'(done),       32'd0);
        chk("rst_mid start",  32'(mult_start), 32'd0);
        chk("rst_mid in1",    32'(mult_in1),   32'd0);
        chk("rst_mid result", 32'(result),     32'd0);
        req = '0;
        @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
        hv = '{2'b11, 16'h0002, 16'h0002, 16'h0003, 16'h0003, 2'b01, 16'h0004};
        run_op(hv, "post_rst both");
        hv = '{2'b10, 16'h0000, 16'h0000, 16'h0009, 16'h0009, 2'b10, 16'h0051};
        run_op(hv, "post_rst r1");
        req = '0;
        @(negedge clk);

        // Multiplier never finishes.
        mdl_en = 1'b0;
        req    = 2'b01;
        op_a   = {16'h0000, 16'h0001};
        op_b   = {16'h0000, 16'h0001};
        wait_start(got);
        chk("stall start seen", 32'(got), 32'd1);
`ifdef MULT_ARB_TIMEOUT_EN
        n   = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            n++;
            if (done != 2'b00) got = 1'b1;
        end
        req = '0;
        chk("timeout done",    32'(done),   32'd1);
        chk("timeout err",     32'(err),    32'd1);
        chk("timeout result",  32'(result), 32'd0);
        chk("timeout latency", 32'(n),      32'(TIMEOUT + 1));
        @(negedge clk);
        chk("timeout err pulse", 32'(err), 32'd0);
        tb_fin = 1'b1;
        @(negedge clk);
        tb_fin = 1'b0;
        chk("late_fin busy", 32'(busy), 32'd0);
        chk("late_fin done", 32'(done), 32'd0);
`else
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done != 2'b00) seen++;
        end
        chk("stall no done", 32'(seen), 32'd0);
        chk("stall busy",    32'(busy), 32'd1);
        chk("stall err",     32'(err),  32'd0);
        chk("stall gnt",     32'(gnt),  32'd1);
        req  = '0;
        nRST = 1'b0;
        @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
        chk("stall recover busy", 32'(busy), 32'd0);
`endif
        mdl_en = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
